div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle iterative integer divider for the RISC-V M-extension ops DIV/DIVU/REM/REMU.
- Complements the pipelined multiplier: it sits beside it in the execute stage and uses the same start/done handshake toward the functional-unit issue logic.
- Uses radix-2^R restoring division on absolute values, then applies a sign fix-up. One divide is in flight at a time; the unit supports squash on flush.

Parameters:
- XLEN, 64, operand/result width.
- BITS_PER_CYCLE, 2, quotient bits retired per RUN cycle (R). Legal values: 1, 2, 4. XLEN % R == 0.

Ports:
- clock  in  1  system clock, posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy==0
- func  in  2  op select: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  XLEN  rs1 value
- divisor  in  XLEN  rs2 value
- flush  in  1  squash in-flight op (mispredict)
- busy  out  1  high from the edge accepting start until the edge that asserts done
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  quotient or remainder per func; held until next accepted start

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high, named `reset`.
- Reset values: state=IDLE; busy=0; done=0; result=0; internal counters and registers=0.
- States:
  - IDLE: on start && !flush, latch func and sign info. Load |dividend| and |divisor| (abs only for DIV/REM), clear the remainder, set count=N=XLEN/R, then go to RUN. Otherwise stay in IDLE.
  - RUN: each cycle performs R restoring steps (shift the remainder left by 1 taking the next dividend MSB; subtract the divisor if the remainder is >= divisor; shift the quotient bit in), then count--. When count reaches 1 at the edge, go to FIX.
  - FIX: negate the quotient if the dividend and divisor signs differ (signed ops only). Negate the remainder if the dividend is negative (signed ops only). Select quotient or remainder into result, pulse done, go to IDLE.
- Latency: start sampled at edge E0. done=1 in the cycle following edge E(N+1); for R=2, XLEN=64 that is 33 edges. done is low in all other cycles.
- A back-to-back start is legal in the cycle done is high (busy=0 then).
- start while busy=1: ignored, no effect on the in-flight op.
- Divide by zero (divisor==0), all func, no trap:
  - quotient = all ones (DIV and DIVU alike).
  - remainder = dividend (unmodified).
- Signed overflow (DIV/REM, dividend = 0x8000_0000_0000_0000, divisor = -1):
  - quotient = dividend.
  - remainder = 0.
- The special cases above are detected in IDLE and flagged. Without the optional feature they still traverse RUN/FIX, so latency is unchanged and FIX forces the mandated values.
- flush: any state goes to IDLE at the next edge. busy=0, no done is produced, result keeps its old value.
  - flush and start in the same cycle: flush wins, start is dropped.
  - flush in the same cycle as done: done still asserts this cycle, because it was registered at the prior edge.
- Reset mid-operation behaves as flush and also clears result.
- Arithmetic: the remainder datapath is XLEN+1 bits so the subtract carry is preserved. Negation is two's complement modulo 2^XLEN.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined: divide-by-zero and signed-overflow requests skip RUN/FIX. Result is written and done pulses after E1 (latency 1). busy is high for that one cycle only.
- Undefined: all ops have the fixed N+1 latency described above.

Decomposition:
- Shared package div_pkg:
  - typedef enum logic [1:0] DIV_FUNC {DIV, DIVU, REM, REMU}.
  - typedef enum DIV_STATE {IDLE, RUN, FIX}.
  - localparam for XLEN default.
  - Function is_signed(func).
- Sub-module div_step: combinational single-radix-2 restoring step (remainder, divisor, dividend bit → next remainder, quotient bit). Instantiated R times in a chain inside div_unit.

Test Plan:
- DIVU 100/7, R=2 → done exactly 33 edges after start, result 14. REMU same operands → 2.
- DIV -100/7 → 0xFFFF_FFFF_FFFF_FFF2 (-14). REM -100/7 → -2. REM 100/-7 → 2.
- DIV 5/0 → 0xFFFF_FFFF_FFFF_FFFF. REM 5/0 → 5. DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000, REM → 0.
  - Check latency 33 without DIV_FAST_SPECIAL_EN and latency 1 with it.
- Start DIVU 1000/10, assert flush at edge 10 → busy drops next cycle, no done within 40 cycles, result unchanged. Start and flush in the same cycle → busy stays 0.
- Second start asserted while busy → ignored, first result correct. New start issued in the done cycle → accepted, second result correct after another 33 edges.
- Reset asserted mid-RUN → next cycle busy=0, done=0, result=0. Subsequent DIVU 9/3 → 3.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative integer divider (RISC-V M DIV/DIVU/REM/REMU).
package div_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } DIV_FUNC;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } DIV_STATE;

    function automatic logic is_signed(input DIV_FUNC f);
        return (f == DIV) || (f == REM);
    endfunction

    function automatic logic is_rem(input DIV_FUNC f);
        return (f == REM) || (f == REMU);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] divisor,
    input  logic            dividend_bit,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic        [XLEN:0] shifted;
    logic signed [XLEN:0] diff;

    assign shifted = {rem_in, dividend_bit};
    assign diff    = $signed(shifted) - $signed({1'b0, divisor});

    // A set carry-out bit means the shifted remainder already exceeds any XLEN-bit divisor.
    assign q_bit   = shifted[XLEN] | ~diff[XLEN];
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2^R restoring divider with sign fix-up and flush support.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      func,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + ONE;
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? negate(v) : v;
    endfunction

    DIV_STATE        state_q, state_d;
    DIV_FUNC         func_in, func_q;
    logic            neg_quo_q, neg_rem_q, special_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, divisor_q;

    logic            start_ok, fix_fire;
    logic            in_signed, div_zero, sgn_ovf, special;
    logic [XLEN-1:0] quo_fix, rem_fix, result_d;

    assign func_in   = DIV_FUNC'(func);
    assign in_signed = is_signed(func_in);
    assign div_zero  = (divisor == '0);
    assign sgn_ovf   = in_signed && (dividend == INT_MIN) && (&divisor);
    assign special   = div_zero || sgn_ovf;
    assign busy      = (state_q != IDLE);

    // Restoring step chain: BITS_PER_CYCLE steps per RUN cycle, quotient bits shift into quo_q.
    logic [XLEN-1:0]           rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_chain;
    logic [XLEN-1:0]           quo_next;

    assign rem_chain[0] = rem_q;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_step
        div_step #(.XLEN(XLEN)) u_step (
            .rem_in       (rem_chain[k]),
            .divisor      (divisor_q),
            .dividend_bit (quo_q[XLEN-1-k]),
            .rem_out      (rem_chain[k+1]),
            .q_bit        (q_chain[BITS_PER_CYCLE-1-k])
        );
    end

    assign quo_next = {quo_q[XLEN-BITS_PER_CYCLE-1:0], q_chain};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        fix_fire = 1'b0;
        case (state_q)
            IDLE: begin
                start_ok = start && !flush;
                if (start_ok) begin
`ifdef DIV_FAST_SPECIAL_EN
                    state_d = special ? FIX : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                fix_fire = !flush;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // Special cases were preloaded with their final values, so they bypass the sign fix-up.
    always_comb begin
        quo_fix  = (neg_quo_q && !special_q) ? negate(quo_q) : quo_q;
        rem_fix  = (neg_rem_q && !special_q) ? negate(rem_q) : rem_q;
        result_d = is_rem(func_q) ? rem_fix : quo_fix;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            func_q    <= DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            special_q <= 1'b0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            done <= fix_fire;
            if (start_ok) begin
                func_q    <= func_in;
                neg_quo_q <= in_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                neg_rem_q <= in_signed && dividend[XLEN-1];
                special_q <= special;
                cnt_q     <= CNT_W'(N);
                divisor_q <= abs_val(divisor, in_signed);
                if (div_zero) begin
                    quo_q <= '1;
                    rem_q <= dividend;
                end else if (sgn_ovf) begin
                    quo_q <= dividend;
                    rem_q <= '0;
                end else begin
                    quo_q <= abs_val(dividend, in_signed);
                    rem_q <= '0;
                end
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (!special_q) begin
                    rem_q <= rem_chain[BITS_PER_CYCLE];
                    quo_q <= quo_next;
                end
            end
            if (fix_fire) begin
                result <= result_d;
            end
        end
    end

endmodule
